// File: rtl/wc_io_mux.sv
`default_nettype none
// ============================================================================
// Module   : wc_io_mux
// Brief    : Pin-reduction shim. Deserialises narrow input beats into the
//            core D word and serialises the core Z word onto narrow pins.
// Revision : 1.0 - initial release
// ============================================================================
module wc_io_mux #(
    parameter int CORE_IN_W  = 80,
    parameter int CORE_OUT_W = 40,
    parameter int PIN_IN_W   = 16,
    parameter int PIN_OUT_W  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [PIN_IN_W-1:0]   pin_din,
    input  logic                  pin_din_vld,
    input  logic                  pin_din_sof,
    output logic [CORE_IN_W-1:0]  core_d,
    output logic                  core_d_vld,
    input  logic [CORE_OUT_W-1:0] core_z,
    input  logic                  core_z_vld,
    output logic [PIN_OUT_W-1:0]  pin_dout,
    output logic                  pin_dout_vld,
    output logic                  pin_dout_sof,
    output logic                  ovf
);

    localparam int c_in_beats  = (CORE_IN_W + PIN_IN_W - 1) / PIN_IN_W;
    localparam int c_out_beats = (CORE_OUT_W + PIN_OUT_W - 1) / PIN_OUT_W;
    localparam int c_in_pad_w  = c_in_beats * PIN_IN_W;
    localparam int c_out_pad_w = c_out_beats * PIN_OUT_W;
    localparam int c_in_cnt_w  = (c_in_beats > 1) ? $clog2(c_in_beats) : 1;
    localparam int c_out_cnt_w = $clog2(c_out_beats + 1);
    localparam logic [c_in_cnt_w-1:0]  c_in_last  = c_in_cnt_w'(c_in_beats - 1);
    localparam logic [c_out_cnt_w-1:0] c_out_last = c_out_cnt_w'(c_out_beats);

    // ------------------------------------------------------------------
    // Deserialiser
    // ------------------------------------------------------------------
    logic [c_in_cnt_w-1:0] r_in_cnt;
    logic [c_in_pad_w-1:0] r_stage;
    logic [c_in_pad_w-1:0] w_stage_nxt;
    logic [c_in_cnt_w-1:0] w_slot;
    logic                  w_word_done;
    logic [CORE_IN_W-1:0]  r_core_d;
    logic                  r_core_d_vld;

    always_comb begin
        w_slot      = pin_din_sof ? '0 : r_in_cnt;
        w_stage_nxt = r_stage;
        w_stage_nxt[w_slot*PIN_IN_W +: PIN_IN_W] = pin_din;
        w_word_done = pin_din_vld && (w_slot == c_in_last);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_in_cnt     <= '0;
            r_stage      <= '0;
            r_core_d     <= '0;
            r_core_d_vld <= 1'b0;
        end else begin
            r_core_d_vld <= 1'b0;
            if (pin_din_vld) begin
                r_stage <= w_stage_nxt;
                if (w_word_done) begin
                    r_core_d     <= w_stage_nxt[CORE_IN_W-1:0];
                    r_core_d_vld <= 1'b1;
                    r_in_cnt     <= '0;
                end else begin
                    r_in_cnt <= w_slot + c_in_cnt_w'(1);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Serialiser
    // ------------------------------------------------------------------
    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t                 r_state, w_state_nxt;
    logic [c_out_pad_w-1:0] r_shift, w_shift_nxt;
    logic [c_out_cnt_w-1:0] r_out_cnt, w_out_cnt_nxt;
    logic [CORE_OUT_W-1:0]  r_hold, w_hold_nxt;
    logic                   r_hold_full, w_hold_full_nxt;
    logic [PIN_OUT_W-1:0]   r_dout, w_dout_nxt;
    logic                   r_dout_vld, w_dout_vld_nxt;
    logic                   r_dout_sof, w_dout_sof_nxt;
    logic                   r_ovf, w_ovf_nxt;
    logic [c_out_pad_w-1:0] w_z_pad, w_hold_pad, w_load_word;
    logic                   w_load, w_last, w_drain;

    always_comb begin
        w_z_pad                     = '0;
        w_z_pad[CORE_OUT_W-1:0]     = core_z;
        w_hold_pad                  = '0;
        w_hold_pad[CORE_OUT_W-1:0]  = r_hold;

        w_state_nxt     = r_state;
        w_shift_nxt     = r_shift;
        w_out_cnt_nxt   = r_out_cnt;
        w_hold_nxt      = r_hold;
        w_hold_full_nxt = r_hold_full;
        w_dout_nxt      = '0;
        w_dout_vld_nxt  = 1'b0;
        w_dout_sof_nxt  = 1'b0;
        w_ovf_nxt       = r_ovf;
        w_load          = 1'b0;
        w_load_word     = w_z_pad;
        w_last          = (r_state == S_SHIFT) && (r_out_cnt == c_out_last);
        w_drain         = w_last && r_hold_full;

        case (r_state)
            S_IDLE: begin
                if (core_z_vld) begin
                    w_load = 1'b1;
                end
            end
            S_SHIFT: begin
                if (!w_last) begin
                    w_dout_nxt     = r_shift[PIN_OUT_W-1:0];
                    w_shift_nxt    = r_shift >> PIN_OUT_W;
                    w_out_cnt_nxt  = r_out_cnt + c_out_cnt_w'(1);
                    w_dout_vld_nxt = 1'b1;
                end else if (r_hold_full) begin
                    w_load          = 1'b1;
                    w_load_word     = w_hold_pad;
                    w_hold_full_nxt = 1'b0;
                end else if (core_z_vld) begin
                    w_load = 1'b1;
                end else begin
                    w_state_nxt   = S_IDLE;
                    w_out_cnt_nxt = '0;
                end
                // A draining holding slot can accept a new word in the same cycle.
                if (core_z_vld) begin
                    if (w_drain || (!r_hold_full && !w_last)) begin
                        w_hold_nxt      = core_z;
                        w_hold_full_nxt = 1'b1;
                    end else if (r_hold_full) begin
                        w_ovf_nxt = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        if (w_load) begin
            w_state_nxt    = S_SHIFT;
            w_dout_nxt     = w_load_word[PIN_OUT_W-1:0];
            w_shift_nxt    = w_load_word >> PIN_OUT_W;
            w_out_cnt_nxt  = c_out_cnt_w'(1);
            w_dout_vld_nxt = 1'b1;
            w_dout_sof_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift     <= '0;
            r_out_cnt   <= '0;
            r_hold      <= '0;
            r_hold_full <= 1'b0;
            r_dout      <= '0;
            r_dout_vld  <= 1'b0;
            r_dout_sof  <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            r_shift     <= w_shift_nxt;
            r_out_cnt   <= w_out_cnt_nxt;
            r_hold      <= w_hold_nxt;
            r_hold_full <= w_hold_full_nxt;
            r_dout      <= w_dout_nxt;
            r_dout_vld  <= w_dout_vld_nxt;
            r_dout_sof  <= w_dout_sof_nxt;
            r_ovf       <= w_ovf_nxt;
        end
    end

    assign core_d       = r_core_d;
    assign core_d_vld   = r_core_d_vld;
    assign pin_dout     = r_dout;
    assign pin_dout_vld = r_dout_vld;
    assign pin_dout_sof = r_dout_sof;
    assign ovf          = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_wc_io_mux.sv
`default_nettype none
// ============================================================================
// Module   : tb_wc_io_mux
// Brief    : Scoreboard bench for wc_io_mux with a cycle-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wc_io_mux;

    localparam int CIW = 80;
    localparam int COW = 40;
    localparam int PIW = 16;
    localparam int POW = 8;
    localparam int IB  = 5;
    localparam int OB  = 5;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [PIW-1:0] pin_din = '0;
    logic           pin_din_vld = 1'b0;
    logic           pin_din_sof = 1'b0;
    logic [CIW-1:0] core_d;
    logic           core_d_vld;
    logic [COW-1:0] core_z = '0;
    logic           core_z_vld = 1'b0;
    logic [POW-1:0] pin_dout;
    logic           pin_dout_vld;
    logic           pin_dout_sof;
    logic           ovf;

    // Second instance with a 24-bit input bus (4 beats, 8 live bits in the last)
    logic [23:0]    p2_din = '0;
    logic           p2_vld = 1'b0;
    logic           p2_sof = 1'b0;
    logic [CIW-1:0] d2_core_d;
    logic           d2_core_d_vld;
    logic [COW-1:0] d2_core_z = '0;
    logic           d2_core_z_vld = 1'b0;
    logic [POW-1:0] d2_pin_dout;
    logic           d2_pin_dout_vld;
    logic           d2_pin_dout_sof;
    logic           d2_ovf;

    always #5 clk = ~clk;

    wc_io_mux dut (
        .clk(clk), .rst(rst),
        .pin_din(pin_din), .pin_din_vld(pin_din_vld), .pin_din_sof(pin_din_sof),
        .core_d(core_d), .core_d_vld(core_d_vld),
        .core_z(core_z), .core_z_vld(core_z_vld),
        .pin_dout(pin_dout), .pin_dout_vld(pin_dout_vld), .pin_dout_sof(pin_dout_sof),
        .ovf(ovf)
    );

    wc_io_mux #(.CORE_IN_W(80), .CORE_OUT_W(40), .PIN_IN_W(24), .PIN_OUT_W(8)) dut2 (
        .clk(clk), .rst(rst),
        .pin_din(p2_din), .pin_din_vld(p2_vld), .pin_din_sof(p2_sof),
        .core_d(d2_core_d), .core_d_vld(d2_core_d_vld),
        .core_z(d2_core_z), .core_z_vld(d2_core_z_vld),
        .pin_dout(d2_pin_dout), .pin_dout_vld(d2_pin_dout_vld), .pin_dout_sof(d2_pin_dout_sof),
        .ovf(d2_ovf)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        int             v;
        logic [CIW-1:0] d;
    } dword_t;

    typedef struct {
        int             v;
        logic [POW-1:0] b;
        logic           sof;
    } beat_t;

    dword_t         dq[$];
    beat_t          bq[$];
    logic [PIW-1:0] m_beats[IB];
    int             m_idx = 0;
    int             m_last_start = -100;
    int             m_last_end = -100;
    bit             m_ovf = 1'b0;
    int             m_ovf_v = 0;

    task automatic model_reset();
        dq.delete();
        bq.delete();
        m_idx        = 0;
        m_last_start = -100;
        m_last_end   = -100;
        m_ovf        = 1'b0;
        m_ovf_v      = 0;
    endtask

    // Drive one cycle of stimulus (called just after a rising edge) and
    // update the reference model for what the DUT must do with it.
    task automatic step(input bit dv, input logic [PIW-1:0] d, input bit s,
                        input bit zv, input logic [COW-1:0] z);
        logic [IB*PIW-1:0] w;
        int                st;
        dword_t            de;
        beat_t             be;
        pin_din     = d;
        pin_din_vld = dv;
        pin_din_sof = s;
        core_z      = z;
        core_z_vld  = zv;
        if (dv) begin
            if (s) m_idx = 0;
            m_beats[m_idx] = d;
            m_idx++;
            if (m_idx == IB) begin
                for (int k = 0; k < IB; k++) w[k*PIW +: PIW] = m_beats[k];
                de.v = cyc + 1;
                de.d = w[CIW-1:0];
                dq.push_back(de);
                m_idx = 0;
            end
        end
        if (zv) begin
            if (m_last_start > cyc + 1) begin
                if (!m_ovf) m_ovf_v = cyc + 1;
                m_ovf = 1'b1;
            end else begin
                st = (cyc + 1 > m_last_end + 1) ? cyc + 1 : m_last_end + 1;
                for (int k = 0; k < OB; k++) begin
                    be.v   = st + k;
                    be.b   = POW'(z >> (k * POW));
                    be.sof = (k == 0);
                    bq.push_back(be);
                end
                m_last_start = st;
                m_last_end   = st + OB - 1;
            end
        end
        @(posedge clk);
        #1;
        pin_din_vld = 1'b0;
        pin_din_sof = 1'b0;
        core_z_vld  = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, '0, 0, 0, '0);
    endtask

    // Monitor: compares presented outputs against the scoreboard queues.
    always @(negedge clk) begin
        if (!rst) begin
            if (core_d_vld) begin
                if (dq.size() == 0) begin
                    check("core_d_vld_spurious", core_d_vld, 1'b0);
                end else begin
                    dword_t e;
                    e = dq.pop_front();
                    check("core_d_cycle", cyc, e.v);
                    check("core_d", core_d, e.d);
                end
            end
            if (pin_dout_vld) begin
                if (bq.size() == 0) begin
                    check("pin_dout_vld_spurious", pin_dout_vld, 1'b0);
                end else begin
                    beat_t e;
                    e = bq.pop_front();
                    check("pin_dout_cycle", cyc, e.v);
                    check("pin_dout", pin_dout, e.b);
                    check("pin_dout_sof", pin_dout_sof, e.sof);
                end
            end
            check("ovf", ovf, m_ovf && (cyc >= m_ovf_v));
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_core_d"}, core_d, '0);
        check({tag, "_core_d_vld"}, core_d_vld, 1'b0);
        check({tag, "_pin_dout"}, pin_dout, '0);
        check({tag, "_pin_dout_vld"}, pin_dout_vld, 1'b0);
        check({tag, "_pin_dout_sof"}, pin_dout_sof, 1'b0);
        check({tag, "_ovf"}, ovf, 1'b0);
    endtask

    initial begin
        logic [23:0]    b2[4];
        logic [CIW-1:0] exp2;
        int             budget;

        #1;
        check_all_zero("reset");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Five beats forming 0x0005_0004_0003_0002_0001
        for (int i = 1; i <= 5; i++) step(1, PIW'(i), (i == 1), 0, '0);
        idle(2);

        // Partial word abandoned by a sof resync
        for (int i = 0; i < 3; i++) step(1, 16'h1234, (i == 0), 0, '0);
        step(1, 16'hAAAA, 1, 0, '0);
        for (int i = 0; i < 4; i++) step(1, 16'hBBBB, 0, 0, '0);
        idle(2);

        // Single result, two back-to-back, three back-to-back (overflow)
        step(0, '0, 0, 1, 40'h12_3456_789A);
        idle(8);
        step(0, '0, 0, 1, 40'hA1_A2A3_A4A5);
        step(0, '0, 0, 1, 40'hB1_B2B3_B4B5);
        idle(14);
        step(0, '0, 0, 1, 40'hC1_C2C3_C4C5);
        step(0, '0, 0, 1, 40'hD1_D2D3_D4D5);
        step(0, '0, 0, 1, 40'hE1_E2E3_E4E5);
        idle(14);

        // Reset during beat 3 of an output word and a partial input word
        step(1, 16'h0F0F, 1, 0, '0);
        step(1, 16'hF0F0, 0, 1, 40'h55_6677_8899);
        idle(3);
        rst = 1'b1;
        #1;
        check_all_zero("midrst");
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 5; i++) step(1, PIW'(16'h1100 + i), 0, 0, '0);
        idle(3);

        // Randomised traffic on both directions
        for (int i = 0; i < 600; i++) begin
            bit dv, zv;
            dv = ($urandom_range(0, 9) < 7);
            zv = ($urandom_range(0, 9) < 2);
            step(dv, PIW'($urandom), dv && ($urandom_range(0, 9) == 0), zv,
                 {8'($urandom), 32'($urandom)});
        end

        budget = 0;
        while ((bq.size() != 0 || dq.size() != 0) && budget < 200) begin
            idle(1);
            budget++;
        end
        check("drain_beats_left", bq.size(), 0);
        check("drain_words_left", dq.size(), 0);

        // 24-bit pins: top 16 bits of beat 3 must be ignored
        for (int k = 0; k < 4; k++) b2[k] = 24'($urandom) | 24'hFF0000;
        exp2 = {b2[3][7:0], b2[2], b2[1], b2[0]};
        for (int k = 0; k < 4; k++) begin
            p2_din = b2[k];
            p2_vld = 1'b1;
            p2_sof = (k == 0);
            @(posedge clk);
            #1;
        end
        p2_vld = 1'b0;
        p2_sof = 1'b0;
        check("w24_core_d_vld", d2_core_d_vld, 1'b1);
        check("w24_core_d", d2_core_d, exp2);
        @(posedge clk);
        #1;
        check("w24_core_d_vld_pulse", d2_core_d_vld, 1'b0);
        check("w24_core_d_hold", d2_core_d, exp2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/wc_io_mux.md
# wc_io_mux

Pin-reduction shim between the chip pad ring and the Winograd core. It deserialises a narrow input pin bus into the core's full-width `D` word and serialises the core's full-width `Z` result onto a narrow output pin bus. This lets later chip generations keep a wide core while cutting pad count. It is generalised over core and pin widths, and adds framing, start-of-frame resync, a one-word output holding buffer and overflow detection.

## Interface
- `CORE_IN_W`, default 80: core input word width (`D`).
- `CORE_OUT_W`, default 40: core output word width (`Z`).
- `PIN_IN_W`, default 16: input pin bus width; must satisfy 1 ≤ `PIN_IN_W` ≤ `CORE_IN_W`.
- `PIN_OUT_W`, default 8: output pin bus width; must satisfy 1 ≤ `PIN_OUT_W` ≤ `CORE_OUT_W`.
- Derived: `IN_BEATS` = ceil(`CORE_IN_W`/`PIN_IN_W`); `OUT_BEATS` = ceil(`CORE_OUT_W`/`PIN_OUT_W`).

Ports (name, direction, width, meaning):
- `clk`  in  1  single clock.
- `rst`  in  1  asynchronous, active-high reset.
- `pin_din`  in  `PIN_IN_W`  input beat.
- `pin_din_vld`  in  1  beat qualifier.
- `pin_din_sof`  in  1  beat is beat 0 of a word; only meaningful when `pin_din_vld`=1.
- `core_d`  out  `CORE_IN_W`  assembled word to core.
- `core_d_vld`  out  1  one-cycle pulse when `core_d` updates.
- `core_z`  in  `CORE_OUT_W`  core result.
- `core_z_vld`  in  1  `core_z` is valid this cycle.
- `pin_dout`  out  `PIN_OUT_W`  output beat.
- `pin_dout_vld`  out  1  output beat valid.
- `pin_dout_sof`  out  1  output beat 0 marker.
- `ovf`  out  1  sticky flag: a result was dropped.

## Operation
- Word layout is little-endian. Beat k carries word bits [k·W+W−1 : k·W]. Bits of the final beat that fall above the word width are ignored on input and driven 0 on output.
- Deserialiser:
  - Beat counter runs 0..`IN_BEATS`−1 and advances only on `pin_din_vld`.
  - `pin_din_vld`=1 with `pin_din_sof`=1 forces the beat to slot 0 and sets the counter to 1, discarding any partial word. Resync is never flagged.
  - On acceptance of beat `IN_BEATS`−1: the staging register is copied to `core_d`, `core_d_vld` pulses, and the counter wraps to 0.
  - `core_d` holds its value between words.
  - When `IN_BEATS`=1, every valid beat completes a word.
- Serialiser FSM:
  - IDLE: `pin_dout_vld`=0. On `core_z_vld`, load the shifter and go to SHIFT.
  - SHIFT: emit one beat per cycle, `OUT_BEATS` beats total.
    - After the last beat, if the holding register is full: move it to the shifter, stay in SHIFT, no gap cycle.
    - Otherwise, after the last beat, return to IDLE.
  - `core_z_vld` while in SHIFT:
    - Holding empty, or holding being drained this cycle: capture into holding.
    - Holding full and not draining: drop the word and set `ovf`.
  - `core_z_vld` in the same cycle as the last beat with holding empty: load the shifter directly; next beat 0 follows with no gap.
  - `ovf` clears only on `rst`.
- Reset mid-operation discards partial input words, the shifter contents and the holding contents.

## Timing
- Reset values: `core_d`=0, `core_d_vld`=0, `pin_dout`=0, `pin_dout_vld`=0, `pin_dout_sof`=0, `ovf`=0. Beat counter=0, FSM=IDLE, holding empty.
- All outputs are registered.
- Input latency: the final beat is sampled at edge E; `core_d` and `core_d_vld` are visible in the cycle after E.
- Output latency: `core_z_vld` is sampled at edge E while IDLE; beat 0, with `pin_dout_sof`=1, is visible in the cycle after E. Beats 1..`OUT_BEATS`−1 follow on consecutive cycles.
- Sustained throughput is one result every `OUT_BEATS` cycles. A second result arriving within one word time is absorbed by holding; a third is dropped.
- Input accepts back-to-back beats with no gaps required. Gaps between beats are allowed.

## Test plan
- Reset, then with defaults send 5 beats 0x0001..0x0005 (sof on the first) -> `core_d`=0x0005_0004_0003_0002_0001, single `core_d_vld` pulse in the cycle after beat 5.
- Send 3 beats, then a sof beat 0xAAAA followed by 4 beats 0xBBBB -> exactly one `core_d_vld`, `core_d`=0xBBBB_BBBB_BBBB_BBBB_AAAA.
- `core_z`=0x12_3456_789A with `core_z_vld` for one cycle -> `pin_dout` 0x9A, 0x78, 0x56, 0x34, 0x12 on 5 consecutive cycles, sof on the first, `ovf`=0.
- `core_z_vld` on 2 consecutive cycles (words A, B) -> 10 contiguous beats, A then B, sof on beats 0 and 5, `ovf`=0.
- `core_z_vld` on 3 consecutive cycles -> only the first two words are emitted; `ovf` rises the cycle after the third strobe and stays 1 until `rst`.
- Assert `rst` during beat 3 of an output word and during a partial input word -> all outputs 0 immediately. After release, 5 fresh input beats yield one correct `core_d`.
- With `PIN_IN_W`=24 and `CORE_IN_W`=80 (4 beats) -> the top 16 bits of beat 3 are ignored.
